// File: rtl/hdc_pkg.sv
// Shared definitions for the hyperdimensional feature bundler.
// Holds the default geometry, width/threshold helpers and the bundler FSM state type.
package hdc_pkg;

  localparam int unsigned FeatureCountDef = 617;
  localparam int unsigned ChunkWDef       = 64;
  localparam int unsigned LanesDef        = 8;

  // Width needed to hold a popcount in the range 0..fc.
  function automatic int unsigned hdc_sum_w(input int unsigned fc);
    return $clog2(fc + 1);
  endfunction

  // Majority threshold: strictly more than half of the features set.
  function automatic int unsigned hdc_maj_thr(input int unsigned fc);
    return (fc + 1) / 2;
  endfunction

  typedef enum logic {
    StAccum,
    StHold
  } bundler_state_e;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a W-bit vector.
// Ports: bits_i - input vector; count_o - number of set bits, $clog2(W+1) wide.
module popcount_tree #(
  parameter  int unsigned W    = 64,
  localparam int unsigned CntW = $clog2(W + 1)
) (
  input  logic [W-1:0]    bits_i,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum = sum + CntW'(bits_i[i]);
    end
  end

  assign count_o = sum;

endmodule

// File: rtl/seq_bundler.sv
// Sequential feature bundler: accumulates per-lane popcounts of a FEATURE_COUNT-bit feature
// vector delivered as NUM_CHUNKS beats of CHUNK_W bits per lane, then thresholds each sum.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - chunk beat handshake; in_bits carries LANES chunks
//   thr, mode           - runtime threshold / majority select, sampled on chunk 0
//   out_valid/out_ready - result handshake; out_bits thresholded, out_sums raw sums
module seq_bundler
  import hdc_pkg::*;
#(
  parameter  int unsigned FEATURE_COUNT = FeatureCountDef,
  parameter  int unsigned CHUNK_W       = ChunkWDef,
  parameter  int unsigned LANES         = LanesDef,
  localparam int unsigned SUM_W         = hdc_sum_w(FEATURE_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*CHUNK_W-1:0] in_bits,
  input  logic [SUM_W-1:0]         thr,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_bits,
  output logic [LANES*SUM_W-1:0]   out_sums
);

  localparam int unsigned NumChunks = (FEATURE_COUNT + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned MajThr    = hdc_maj_thr(FEATURE_COUNT);
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned PcW       = $clog2(CHUNK_W + 1);
  localparam int unsigned LastBits  = FEATURE_COUNT - (NumChunks - 1) * CHUNK_W;
  // Keeps only the feature bits that exist in the final, partially filled chunk.
  localparam logic [CHUNK_W-1:0] LastMask = {CHUNK_W{1'b1}} >> (CHUNK_W - LastBits);
  localparam logic [CntW-1:0]    LastIdx  = CntW'(NumChunks - 1);

  bundler_state_e         state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SUM_W-1:0]       acc_q [LANES];
  logic [SUM_W-1:0]       acc_d [LANES];
  logic [SUM_W-1:0]       thr_q, thr_d;
  logic                   mode_q, mode_d;
  logic [LANES-1:0]       out_bits_q, out_bits_d;
  logic [LANES*SUM_W-1:0] out_sums_q, out_sums_d;

  logic                   beat, first_beat, last_beat;
  logic [PcW-1:0]         pc [LANES];
  logic [SUM_W-1:0]       sum_new [LANES];
  logic [SUM_W-1:0]       tgt;

  assign beat       = in_valid && (state_q == StAccum);
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LastIdx);

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [CHUNK_W-1:0] chunk;
    assign chunk = in_bits[l*CHUNK_W +: CHUNK_W] & (last_beat ? LastMask : {CHUNK_W{1'b1}});

    popcount_tree #(
      .W (CHUNK_W)
    ) u_popcount (
      .bits_i  (chunk),
      .count_o (pc[l])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    thr_d      = thr_q;
    mode_d     = mode_q;
    out_bits_d = out_bits_q;
    out_sums_d = out_sums_q;
    for (int l = 0; l < int'(LANES); l++) begin
      acc_d[l]   = acc_q[l];
      sum_new[l] = acc_q[l] + SUM_W'(pc[l]);
    end
    // On chunk 0 the live inputs are the ones being sampled, so use them directly; this also
    // covers a single-chunk configuration where the first beat is the last.
    if (first_beat ? mode : mode_q) begin
      tgt = SUM_W'(MajThr);
    end else begin
      tgt = first_beat ? thr : thr_q;
    end

    unique case (state_q)
      StAccum: begin
        if (beat) begin
          if (first_beat) begin
            thr_d  = thr;
            mode_d = mode;
          end
          if (last_beat) begin
            for (int l = 0; l < int'(LANES); l++) begin
              out_sums_d[l*SUM_W +: SUM_W] = sum_new[l];
              out_bits_d[l]                = (sum_new[l] >= tgt);
              acc_d[l]                     = '0;
            end
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            for (int l = 0; l < int'(LANES); l++) begin
              acc_d[l] = sum_new[l];
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccum;
      cnt_q      <= '0;
      thr_q      <= '0;
      mode_q     <= 1'b0;
      out_bits_q <= '0;
      out_sums_q <= '0;
      for (int l = 0; l < int'(LANES); l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      mode_q     <= mode_d;
      out_bits_q <= out_bits_d;
      out_sums_q <= out_sums_d;
      for (int l = 0; l < int'(LANES); l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign out_bits  = out_bits_q;
  assign out_sums  = out_sums_q;

endmodule

// File: tb/tb_seq_bundler.sv
// Directed self-checking bench for seq_bundler at default geometry (617 features, 64-bit
// chunks, 8 lanes). Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_bundler;

  localparam int FC = 617;
  localparam int CW = 64;
  localparam int LN = 8;
  localparam int SW = 10;
  localparam int NC = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [LN*CW-1:0] in_bits;
  logic [SW-1:0]    thr;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [LN-1:0]    out_bits;
  logic [LN*SW-1:0] out_sums;

  int n_vec = 0;
  int n_err = 0;
  int lane_cnt [LN];

  always #5 clk = ~clk;

  seq_bundler u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .thr       (thr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_sums  (out_sums)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Lane l carries lane_cnt[l] ones packed from feature 0 upward; >= CW*NC fills every bit.
  function automatic logic [LN*CW-1:0] chunk_data(input int k);
    logic [LN*CW-1:0] d;
    logic [CW-1:0]    one;
    logic [CW-1:0]    lb;
    int               ones;
    d   = '0;
    one = 1;
    for (int l = 0; l < LN; l++) begin
      ones = lane_cnt[l] - k * CW;
      if (ones < 0) ones = 0;
      lb = (ones >= CW) ? '1 : ((one << ones) - one);
      d[l*CW +: CW] = lb;
    end
    return d;
  endfunction

  task automatic set_all(input int c);
    for (int l = 0; l < LN; l++) lane_cnt[l] = c;
  endtask

  // Entered and left on a falling edge; the beat transfers on the rising edge in between.
  task automatic send_beat(input logic [LN*CW-1:0] d, input logic [SW-1:0] t, input logic m);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_bits  = d;
    thr      = t;
    mode     = m;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("beat_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // thr/mode are only meaningful on chunk 0; afterwards they are scrambled on purpose.
  task automatic send_vector(input logic [SW-1:0] t, input logic m, input int max_gap);
    for (int k = 0; k < NC; k++) begin
      if (k == 0) send_beat(chunk_data(0), t, m);
      else send_beat(chunk_data(k), SW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      thr  = SW'($urandom_range(0, 1023));
      mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic collect(input string tag, input logic [LN-1:0] exp_bits);
    int w;
    int e;
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    for (int l = 0; l < LN; l++) begin
      e = (lane_cnt[l] > FC) ? FC : lane_cnt[l];
      check_eq($sformatf("%s_sum%0d", tag, l), 32'(out_sums[l*SW +: SW]), e);
    end
    check_eq({tag, "_bits"}, 32'(out_bits), 32'(exp_bits));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    thr       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    set_all(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_out_bits", 32'(out_bits), 32'd0);
    check_eq("rst_out_sums_lo", out_sums[31:0], 32'd0);

    // All ones including masked tail bits, threshold exactly the feature count.
    set_all(1000);
    send_vector(10'd617, 1'b0, 0);
    collect("ones617", 8'hFF);

    set_all(0);
    send_vector(10'd0, 1'b0, 0);
    collect("zeros_thr0", 8'hFF);

    set_all(1000);
    send_vector(10'd618, 1'b0, 0);
    collect("ones618", 8'h00);

    // Majority: 309 is the smallest passing count.
    set_all(0);
    lane_cnt[0] = 309;
    lane_cnt[1] = 308;
    send_vector(10'd700, 1'b1, 0);
    collect("maj", 8'h01);

    // Back-pressure: five cycles with out_ready low.
    set_all(1000);
    send_vector(10'd100, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_valid%0d", i), {31'b0, out_valid}, 32'd1);
      check_eq($sformatf("bp_ready%0d", i), {31'b0, in_ready}, 32'd0);
      check_eq($sformatf("bp_sum%0d", i), 32'(out_sums[SW-1:0]), 32'd617);
      check_eq($sformatf("bp_bits%0d", i), 32'(out_bits), 32'hFF);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);

    // Reset after four beats, then a back-to-back vector.
    set_all(1000);
    for (int k = 0; k < 4; k++) send_beat(chunk_data(k), 10'd617, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      in_bits = chunk_data(k);
      thr     = (k == 0) ? 10'd617 : 10'd1;
      mode    = 1'b0;
      check_eq($sformatf("lat_idle%0d", k), {31'b0, out_valid}, 32'd0);
      check_eq($sformatf("lat_ready%0d", k), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("lat_done", {31'b0, out_valid}, 32'd1);
    collect("rst_mid", 8'hFF);

    // Reset while holding a result drops it.
    set_all(1000);
    send_vector(10'd0, 1'b0, 0);
    check_eq("hold_pre_rst", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("hold_rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("hold_rst_sums", 32'(out_sums[SW-1:0]), 32'd0);

    // Gaps and mid-vector thr/mode changes must match the gap-free result.
    lane_cnt[0] = 100; lane_cnt[1] = 200; lane_cnt[2] = 300; lane_cnt[3] = 400;
    lane_cnt[4] = 500; lane_cnt[5] = 617; lane_cnt[6] = 0;   lane_cnt[7] = 50;
    send_vector(10'd250, 1'b0, 0);
    collect("nogap_thr", 8'h3C);
    send_vector(10'd250, 1'b0, 3);
    collect("gap_thr", 8'h3C);
    send_vector(10'd5, 1'b1, 3);
    collect("gap_maj", 8'h38);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_bundler.md
SEQ_BUNDLER -- requirements
Module: seq_bundler

Interface
REQ-001 SHALL have parameter FEATURE_COUNT, default 617, number of feature bits bundled into each output dimension.
REQ-002 SHALL have parameter CHUNK_W, default 64, feature bits per lane consumed per accepted beat.
REQ-003 SHALL have parameter LANES, default 8, output dimensions bundled in parallel.
REQ-004 SHALL derive NUM_CHUNKS = ceil(FEATURE_COUNT/CHUNK_W) (default 10), SUM_W = clog2(FEATURE_COUNT+1) (default 10), MAJ_THR = (FEATURE_COUNT+1)/2 (default 309).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 in_valid  in  1  chunk beat valid.
REQ-008 in_ready  out  1  block accepts beat; a beat transfers when in_valid && in_ready.
REQ-009 in_bits  in  LANES*CHUNK_W  lane l chunk at [l*CHUNK_W +: CHUNK_W]; bit j of chunk k = feature k*CHUNK_W+j.
REQ-010 thr  in  SUM_W  runtime threshold.
REQ-011 mode  in  1  0 = use thr, 1 = majority (MAJ_THR).
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_bits  out  LANES  thresholded bit per lane.
REQ-015 out_sums  out  LANES*SUM_W  accumulated popcount per lane, lane l at [l*SUM_W +: SUM_W].

Function
REQ-016 SHALL implement FSM with states ACCUM and HOLD; in_ready = 1 exactly in ACCUM; out_valid = 1 exactly in HOLD.
REQ-017 On each accepted beat, each lane accumulator SHALL add popcount of its chunk; chunk counter increments 0..NUM_CHUNKS-1.
REQ-018 In chunk NUM_CHUNKS-1, bits at feature index >= FEATURE_COUNT SHALL be masked to zero (default: bits 41..63 ignored).
REQ-019 thr and mode SHALL be sampled on the beat with counter 0 and held for the whole vector; later changes ignored.
REQ-020 Effective threshold T = mode ? MAJ_THR : thr; out_bits[l] = (sum_l >= T).
REQ-021 On the accepted beat with counter NUM_CHUNKS-1: out_sums/out_bits SHALL be registered including that beat, counter and accumulators cleared, state -> HOLD; out_valid asserts the next cycle.
REQ-022 In HOLD, out_bits/out_sums SHALL stay stable until out_valid && out_ready; then state -> ACCUM next cycle.
REQ-023 Throughput SHALL be one vector per NUM_CHUNKS+1 cycles with no stalls (one-cycle HOLD bubble).
REQ-024 in_valid low cycles between beats SHALL not alter the result; accumulators hold.
REQ-025 thr = 0 SHALL give all out_bits 1; thr > FEATURE_COUNT SHALL give all 0.
REQ-026 Accumulators SHALL be SUM_W wide and cannot overflow given masking.

Reset
REQ-027 On rst: state ACCUM, counter 0, accumulators 0, sampled thr/mode 0, out_valid 0, out_bits 0, out_sums 0.
REQ-028 rst mid-vector or in HOLD SHALL discard partial/pending result; next accepted beat is chunk 0.

Structure
REQ-029 FEATURE_COUNT/CHUNK_W/LANES defaults, SUM_W and MAJ_THR helpers, and FSM state enum SHALL reside in shared package hdc_pkg.
REQ-030 Per-lane chunk popcount SHALL be a combinational sub-module popcount_tree (parameter W, output clog2(W+1) bits), instantiated LANES times.

Verification
REQ-031 All-ones input, mode 0, thr 617, 10 beats -> out_sums 617 every lane (masked bits ignored), out_bits 0xFF.
REQ-032 All-zeros input, mode 0, thr 0 -> out_sums 0, out_bits 0xFF; then thr 618 with all-ones -> out_bits 0x00.
REQ-033 mode 1, lane0 fed 309 ones, lane1 308 ones, others 0 -> out_bits[0]=1, out_bits[1]=0, sums 309/308.
REQ-034 out_ready low 5 cycles after out_valid -> out_valid held, in_ready 0, outputs stable; accepted on cycle 6, in_ready 1 next cycle.
REQ-035 rst pulse after 4 beats, then full all-ones vector -> out_sums 617 exactly, out_valid 11 cycles after first beat with no stalls.
REQ-036 Random gaps on in_valid and thr changed mid-vector -> results equal gap-free run using thr sampled at chunk 0.
